// File: rtl/bnn_pkg.sv
// BNN accumulator CFU types: function ids, FSM states and chunking helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bnn_pkg;

    // Function ids carried on req_func.
    typedef enum logic [1:0] {
        BNN        = 2'd0,
        BNN_ACC    = 2'd1,
        ACC_RD_CLR = 2'd2,
        ACC_SET    = 2'd3
    } bnn_func_e;

    // One transaction in flight: accept, count chunks, hold response.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RESP  = 2'd2
    } bnn_state_e;

    // Number of CHUNK_W slices in one operand word.
    function automatic int n_chunks(input int data_w, input int chunk_w);
        return data_w / chunk_w;
    endfunction

    // Width of the chunk down-counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bnn_pkg

// File: rtl/cfu_pkg.sv
// CFU-LI shared constants: response status encoding used by every CFU.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cfu_pkg;

    localparam int CFU_STATUS_W = 2;

    localparam logic [CFU_STATUS_W-1:0] CFU_OK    = 2'd0;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR = 2'd1;

endpackage : cfu_pkg

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK_W-bit slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module popcount_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0]         bits_i,
    output logic [$clog2(W):0]   cnt_o
);

    localparam int OUT_W = $clog2(W) + 1;

    // Ripple sum of the set bits; W is small so a linear adder chain is fine.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + OUT_W'(bits_i[i]);
        end
    end

endmodule : popcount_chunk

// File: rtl/bnn_acc_cfu.sv
// Multi-cycle BNN xnor-popcount CFU with persistent accumulator (optional BNN_ACC_CFU_SATURATE_EN).
// Latency: resp_valid high N_CHUNKS+1 cycles after accept for BNN/BNN_ACC, 1 cycle for ACC_RD_CLR/ACC_SET.
// Backpressure: single transaction in flight; response held until resp_ready, req_ready low outside IDLE.
module bnn_acc_cfu
    import cfu_pkg::*;
    import bnn_pkg::*;
#(
    parameter int CFU_LI_VERSION = 'h0100,
    parameter int CFU_N_CFUS     = 1,
    parameter int CFU_CFU_ID_W   = 0,
    parameter int CFU_FUNC_ID_W  = 2,
    parameter int CFU_DATA_W     = 32,
    parameter int CHUNK_W        = 8,
    parameter int ACC_W          = CFU_DATA_W,
    // Physical width of req_cfu; a zero-width id field still needs a one-bit port.
    localparam int CFU_ID_PW     = (CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CFU_ID_PW-1:0]      req_cfu,
    input  logic [CFU_FUNC_ID_W-1:0]  req_func,
    input  logic [CFU_DATA_W-1:0]     req_data0,
    input  logic [CFU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [CFU_STATUS_W-1:0]   resp_status,
    output logic [CFU_DATA_W-1:0]     resp_data
);

    localparam int N_CHUNKS = n_chunks(CFU_DATA_W, CHUNK_W);
    localparam int CNT_W    = cnt_w(N_CHUNKS);
    localparam int PS_W     = $clog2(CFU_DATA_W) + 1;
    localparam int PC_W     = $clog2(CHUNK_W) + 1;

    // Elaboration-time parameter sanity checks.
    if (CFU_LI_VERSION != 'h0100) begin : g_bad_version
        $error("bnn_acc_cfu: unsupported CFU-LI version");
    end
    if (CFU_N_CFUS < 1) begin : g_bad_ncfus
        $error("bnn_acc_cfu: CFU_N_CFUS must be at least 1");
    end
    if (CFU_FUNC_ID_W < 2) begin : g_bad_func_w
        $error("bnn_acc_cfu: CFU_FUNC_ID_W must be at least 2");
    end
    if ((CFU_DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
        $error("bnn_acc_cfu: CHUNK_W must divide CFU_DATA_W");
    end
    if ((ACC_W < PS_W) || (ACC_W > CFU_DATA_W)) begin : g_bad_acc
        $error("bnn_acc_cfu: ACC_W out of range");
    end

    bnn_state_e                state_q;
    logic                      rdy_q;
    logic [CFU_DATA_W-1:0]     shreg_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [PS_W-1:0]           part_q;
    bnn_func_e                 func_q;
    logic [ACC_W-1:0]          acc_q;
    logic                      resp_vld_q;
    logic [CFU_DATA_W-1:0]     resp_dat_q;
    logic [CFU_STATUS_W-1:0]   resp_sts_q;

    logic [PC_W-1:0]           pc_chunk;
    logic [PS_W-1:0]           part_d;
    logic [ACC_W-1:0]          acc_d;
    logic [CFU_DATA_W-1:0]     rd_dat;
    logic                      cfu_err;
    bnn_func_e                 req_fn;

`ifdef BNN_ACC_CFU_SATURATE_EN
    logic                      sat_q;
    logic [ACC_W:0]            acc_sum;
`endif

    assign req_fn = bnn_func_e'(req_func[1:0]);

    // Only ids below CFU_N_CFUS are served; with no id field every request targets us.
    if (CFU_CFU_ID_W > 0) begin : g_id_decode
        assign cfu_err = (int'(req_cfu) >= CFU_N_CFUS);
    end else begin : g_no_id
        assign cfu_err = 1'b0 & (|req_cfu);
    end

    popcount_chunk #(
        .W      (CHUNK_W)
    ) u_popcount (
        .bits_i (shreg_q[CHUNK_W-1:0]),
        .cnt_o  (pc_chunk)
    );

    // Running partial sum, accumulator update candidate and read-back word.
    always_comb begin
        part_d = part_q + PS_W'(pc_chunk);
`ifdef BNN_ACC_CFU_SATURATE_EN
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(part_d);
        acc_d   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        rd_dat  = CFU_DATA_W'(acc_q);
        if (ACC_W < CFU_DATA_W) begin
            rd_dat[CFU_DATA_W-1] = sat_q;
        end
`else
        acc_d   = acc_q + ACC_W'(part_d);
        rd_dat  = CFU_DATA_W'(acc_q);
`endif
    end

    // Transaction FSM with registered handshake outputs and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            part_q     <= '0;
            func_q     <= BNN;
            acc_q      <= '0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            resp_sts_q <= CFU_OK;
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && rdy_q) begin
                        rdy_q   <= 1'b0;
                        shreg_q <= ~(req_data0 ^ req_data1);
                        func_q  <= req_fn;
                        part_q  <= '0;
                        cnt_q   <= CNT_W'(N_CHUNKS - 1);
                        if (cfu_err) begin
                            state_q    <= ST_RESP;
                            resp_vld_q <= 1'b1;
                            resp_dat_q <= '0;
                            resp_sts_q <= CFU_ERROR;
                        end else begin
                            case (req_fn)
                                BNN, BNN_ACC: begin
                                    state_q <= ST_COUNT;
                                end
                                ACC_RD_CLR: begin
                                    state_q    <= ST_RESP;
                                    acc_q      <= '0;
                                    resp_vld_q <= 1'b1;
                                    resp_dat_q <= rd_dat;
                                    resp_sts_q <= CFU_OK;
                                end
                                default: begin
                                    state_q    <= ST_RESP;
                                    acc_q      <= req_data0[ACC_W-1:0];
                                    resp_vld_q <= 1'b1;
                                    resp_dat_q <= CFU_DATA_W'(req_data0[ACC_W-1:0]);
                                    resp_sts_q <= CFU_OK;
                                end
                            endcase
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end

                ST_COUNT: begin
                    part_q  <= part_d;
                    shreg_q <= shreg_q >> CHUNK_W;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q    <= ST_RESP;
                        resp_vld_q <= 1'b1;
                        resp_sts_q <= CFU_OK;
                        if (func_q == BNN_ACC) begin
                            acc_q      <= acc_d;
                            resp_dat_q <= CFU_DATA_W'(acc_d);
                        end else begin
                            resp_dat_q <= CFU_DATA_W'(part_d);
                        end
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state_q    <= ST_IDLE;
                        resp_vld_q <= 1'b0;
                        rdy_q      <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    resp_vld_q <= 1'b0;
                    rdy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef BNN_ACC_CFU_SATURATE_EN
    // Sticky saturation flag: set by a clamped BNN_ACC, cleared by ACC_RD_CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (clk_en) begin
            if (state_q == ST_IDLE && req_valid && rdy_q && !cfu_err && req_fn == ACC_RD_CLR) begin
                sat_q <= 1'b0;
            end else if (state_q == ST_COUNT && cnt_q == '0 && func_q == BNN_ACC && acc_sum[ACC_W]) begin
                sat_q <= 1'b1;
            end
        end
    end
`endif

    assign req_ready   = rdy_q;
    assign resp_valid  = resp_vld_q;
    assign resp_data   = resp_dat_q;
    assign resp_status = resp_sts_q;

endmodule : bnn_acc_cfu

// File: tb/tb_bnn_acc_cfu.sv
// Directed self-checking bench for bnn_acc_cfu at default parameters.
// Latency: measured per transaction in cycles from the accept edge.
// Backpressure: exercised by holding resp_ready low and gating clk_en.
module tb_bnn_acc_cfu;
    import cfu_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clk_en = 1'b1;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic                    req_cfu = 1'b0;
    logic [1:0]              req_func = 2'd0;
    logic [31:0]             req_data0 = '0;
    logic [31:0]             req_data1 = '0;
    logic                    resp_valid;
    logic                    resp_ready = 1'b1;
    logic [CFU_STATUS_W-1:0] resp_status;
    logic [31:0]             resp_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0]             d;
    logic [CFU_STATUS_W-1:0] s;
    int                      lat;
    logic [31:0]             sat_exp;

    always #5 clk = ~clk;

    bnn_acc_cfu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cfu     (req_cfu),
        .req_func    (req_func),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_data   (resp_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and return #1 after the edge that accepts it.
    task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_func  = f;
        req_data0 = a;
        req_data1 = b;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Cycles from the accept edge until resp_valid is seen high (1 = the cycle right after accept).
    task automatic wait_resp(output int l);
        l = 1;
        while (!resp_valid && l < 30) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
    endtask

    task automatic txn(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] dd, output logic [CFU_STATUS_W-1:0] ss, output int l);
        send(f, a, b);
        wait_resp(l);
        dd = resp_data;
        ss = resp_status;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef BNN_ACC_CFU_SATURATE_EN
        sat_exp = 32'hFFFF_FFFF;
`else
        sat_exp = 32'h0000_0010;
`endif
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_status", 64'(resp_status), 64'(CFU_OK));
        check("rst_resp_data", 64'(resp_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // ACC_SET 5, then BNN of all-ones must leave acc alone.
        txn(2'd3, 32'd5, 32'd0, d, s, lat);
        check("set5_data", 64'(d), 64'd5);
        check("set5_lat", 64'(lat), 64'd1);
        txn(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, s, lat);
        check("bnn_ones_data", 64'(d), 64'd32);
        check("bnn_ones_status", 64'(s), 64'(CFU_OK));
        check("bnn_ones_lat", 64'(lat), 64'd5);
        txn(2'd2, 32'd0, 32'd0, d, s, lat);
        check("acc_unchanged", 64'(d), 64'd5);
        check("rdclr_lat", 64'(lat), 64'd1);

        // Alternating patterns and a partial match.
        txn(2'd0, 32'hAAAA_AAAA, 32'h5555_5555, d, s, lat);
        check("bnn_alt_data", 64'(d), 64'd0);
        txn(2'd0, 32'h0000_00FF, 32'h0000_0000, d, s, lat);
        check("bnn_ff_data", 64'(d), 64'd24);

        // Accumulate three full-match rows.
        txn(2'd3, 32'd0, 32'd0, d, s, lat);
        check("set0_data", 64'(d), 64'd0);
        txn(2'd1, 32'h1234_5678, 32'h1234_5678, d, s, lat);
        check("acc_32", 64'(d), 64'd32);
        check("acc_lat", 64'(lat), 64'd5);
        txn(2'd1, 32'h1234_5678, 32'h1234_5678, d, s, lat);
        check("acc_64", 64'(d), 64'd64);
        txn(2'd1, 32'h1234_5678, 32'h1234_5678, d, s, lat);
        check("acc_96", 64'(d), 64'd96);
        txn(2'd2, 32'd0, 32'd0, d, s, lat);
        check("rdclr_96", 64'(d), 64'd96);
        txn(2'd2, 32'd0, 32'd0, d, s, lat);
        check("rdclr_0", 64'(d), 64'd0);

        // Response backpressure with clk_en toggling: 0xF vs 0x3 differs in 2 bits -> 30.
        resp_ready = 1'b0;
        send(2'd0, 32'h0000_000F, 32'h0000_0003);
        wait_resp(lat);
        check("bp_lat", 64'(lat), 64'd5);
        check("bp_data", 64'(resp_data), 64'd30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clk_en = (i == 1);
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(resp_valid), 64'd1);
            check("bp_hold_data", 64'(resp_data), 64'd30);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        clk_en     = 1'b0;
        @(posedge clk);
        #1;
        check("bp_no_hs_gated", 64'(resp_valid), 64'd1);
        @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("bp_consumed", 64'(resp_valid), 64'd0);
        check("bp_ready_next", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        check("bp_single_resp", 64'(resp_valid), 64'd0);

        // Accumulator overflow: wrap or clamp.
        txn(2'd3, 32'hFFFF_FFF0, 32'd0, d, s, lat);
        check("set_big", 64'(d), 64'hFFFF_FFF0);
        txn(2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, d, s, lat);
        check("acc_overflow", 64'(d), 64'(sat_exp));
        txn(2'd2, 32'd0, 32'd0, d, s, lat);
        check("rdclr_overflow", 64'(d), 64'(sat_exp));

        // Reset during COUNT aborts the transaction and clears acc.
        txn(2'd3, 32'd9, 32'd0, d, s, lat);
        check("set9_data", 64'(d), 64'd9);
        send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_resp", 64'(resp_valid), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn(2'd2, 32'd0, 32'd0, d, s, lat);
        check("midrst_acc_zero", 64'(d), 64'd0);
        txn(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, s, lat);
        check("midrst_bnn_data", 64'(d), 64'd32);
        check("midrst_bnn_lat", 64'(lat), 64'd5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bnn_acc_cfu
